// File: rtl/trig_share_arbiter.sv
// -----------------------------------------------------------------------------
// trig_share_arbiter
//
// Time-shares one combinational sine/cosine unit among NUM_REQ requesters.
// A round-robin arbiter accepts one angle at a time. The angle is held on the
// unit input for SETTLE_CYCLES (a multi-cycle path). After that, cos/sin are
// registered and returned with the requester ID over a valid/ready response
// handshake. Exactly one operation is in flight at any time.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester request valid            [NUM_REQ]
//   req_theta   packed angles, lane i at [i*DATA_W +: DATA_W]
//   req_ready   one-hot grant (combinational, IDLE only) [NUM_REQ]
//   trig_theta  registered angle driven to the shared trig unit
//   trig_cos    cosine returned by the shared trig unit
//   trig_sin    sine returned by the shared trig unit
//   resp_valid  result valid
//   resp_ready  consumer accepts result
//   resp_id     requester that owns the result
//   resp_cos    registered cosine
//   resp_sin    registered sine
//   busy        high in every state except IDLE
// -----------------------------------------------------------------------------
module trig_share_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_theta,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         trig_theta,
  input  logic [DATA_W-1:0]         trig_cos,
  input  logic [DATA_W-1:0]         trig_sin,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_cos,
  output logic [DATA_W-1:0]         resp_sin,
  output logic                      busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [DATA_W-1:0]  theta_q;
  logic [CNT_W-1:0]   cnt;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    next_ptr;
  logic [DATA_W-1:0]  grant_theta;

  // Round-robin search: first pending requester at or after rr_ptr, wrapping
  // modulo NUM_REQ (which need not be a power of two).
  // NOTE: every variable assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin : rr_search
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign grant_theta = req_theta[grant_idx*DATA_W +: DATA_W];
  assign next_ptr    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Grants only in IDLE. rst_n is folded in so req_ready stays low while
  // reset is held, even though the state register already reads IDLE.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign trig_theta = theta_q;
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: every register, including the datapath, is reset. This lets an
  // aborted operation leave no visible trace on trig_theta or resp_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      theta_q    <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_cos   <= '0;
      resp_sin   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            theta_q <= grant_theta;
            id_q    <= grant_idx;
            rr_ptr  <= next_ptr;
            cnt     <= CNT_W'(SETTLE_CYCLES);
            state   <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // The angle has now been stable for SETTLE_CYCLES, so the unit
          // output has settled.
          if (cnt == CNT_W'(1)) begin
            resp_cos   <= trig_cos;
            resp_sin   <= trig_sin;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_trig_share_arbiter
//
// Directed bench for trig_share_arbiter (NUM_REQ=4, SETTLE_CYCLES=2).
// A table of single-request vectors covers the grant, latency and data paths.
// Hand-written sequences cover round-robin spacing, backpressure/stability
// and reset mid-operation. The trig unit is modelled as
//   cos = 0x01000000 - theta, sin = theta
// with an override used to disturb the unit output while a result is held.
// -----------------------------------------------------------------------------
module tb_trig_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_theta;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         trig_theta;
  logic [DATA_W-1:0]         trig_cos;
  logic [DATA_W-1:0]         trig_sin;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_cos;
  logic [DATA_W-1:0]         resp_sin;
  logic                      busy;

  logic                      ovr;
  logic [DATA_W-1:0]         ovr_cos;
  logic [DATA_W-1:0]         ovr_sin;

  int n_checks = 0;
  int n_pass   = 0;

  trig_share_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SETTLE_CYCLES(2), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_theta(req_theta), .req_ready(req_ready),
    .trig_theta(trig_theta), .trig_cos(trig_cos), .trig_sin(trig_sin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_cos(resp_cos), .resp_sin(resp_sin), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared trig unit model.
  always_comb begin
    trig_cos = ovr ? ovr_cos : (32'h01000000 - trig_theta);
    trig_sin = ovr ? ovr_sin : trig_theta;
  end

  logic [DATA_W-1:0] lane_theta [NUM_REQ];

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [31:0] exp_cos;
    logic [31:0] exp_sin;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    ovr        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lanes();
    req_theta = {lane_theta[3], lane_theta[2], lane_theta[1], lane_theta[0]};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lane_theta[0] = 32'h00000000;
    lane_theta[1] = 32'h00100000;
    lane_theta[2] = 32'h01921FB5;
    lane_theta[3] = 32'h00400000;

    // Expected results per lane under the model:
    //   lane0 cos 01000000 sin 00000000   lane1 cos 00F00000 sin 00100000
    //   lane2 cos FF6DE04B sin 01921FB5   lane3 cos 00C00000 sin 00400000
    // The rr_ptr after each vector is noted in the trailing comments.
    vecs[0]  = '{4'b0001, 4'b0001, 2'd0, 32'h01000000, 32'h00000000}; // ->1
    vecs[1]  = '{4'b0001, 4'b0001, 2'd0, 32'h01000000, 32'h00000000}; // skip 1..3 ->1
    vecs[2]  = '{4'b1111, 4'b0010, 2'd1, 32'h00F00000, 32'h00100000}; // ->2
    vecs[3]  = '{4'b1111, 4'b0100, 2'd2, 32'hFF6DE04B, 32'h01921FB5}; // ->3
    vecs[4]  = '{4'b1111, 4'b1000, 2'd3, 32'h00C00000, 32'h00400000}; // wrap ->0
    vecs[5]  = '{4'b1111, 4'b0001, 2'd0, 32'h01000000, 32'h00000000}; // ->1
    vecs[6]  = '{4'b1001, 4'b1000, 2'd3, 32'h00C00000, 32'h00400000}; // ->0
    vecs[7]  = '{4'b0110, 4'b0010, 2'd1, 32'h00F00000, 32'h00100000}; // ->2
    vecs[8]  = '{4'b0010, 4'b0010, 2'd1, 32'h00F00000, 32'h00100000}; // ->2
    vecs[9]  = '{4'b0000, 4'b0000, 2'd0, 32'h00000000, 32'h00000000}; // none
    vecs[10] = '{4'b1000, 4'b1000, 2'd3, 32'h00C00000, 32'h00400000}; // ->0
    vecs[11] = '{4'b0100, 4'b0100, 2'd2, 32'hFF6DE04B, 32'h01921FB5}; // ->3

    ovr_cos = '0;
    ovr_sin = '0;
    ovr     = 1'b0;
    drive_lanes();

    // ---- reset state, with requests pending while reset is held ----
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_trig_theta", trig_theta, 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_resp_cos", resp_cos, 32'h0);
    check("rst_resp_sin", resp_sin, 32'h0);
    do_reset();

    // ---- table-driven single operations ----
    for (int v = 0; v < 12; v++) begin
      req_valid = vecs[v].valid;
      drive_lanes();
      @(negedge clk);
      check($sformatf("v%0d_req_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
      if (vecs[v].exp_ready == 4'b0000) begin
        @(posedge clk);
        #1;
        check($sformatf("v%0d_idle_busy", v), 32'(busy), 32'h0);
        req_valid = '0;
        continue;
      end
      @(posedge clk);
      #1;
      // Only the grant cycle needs a stable angle; scramble it afterwards.
      req_valid = '0;
      req_theta = '1;
      @(negedge clk); // T+1
      check($sformatf("v%0d_busy", v), 32'(busy), 32'h1);
      check($sformatf("v%0d_theta_t1", v), trig_theta, lane_theta[vecs[v].exp_id]);
      check($sformatf("v%0d_valid_t1", v), 32'(resp_valid), 32'h0);
      @(negedge clk); // T+2
      check($sformatf("v%0d_theta_t2", v), trig_theta, lane_theta[vecs[v].exp_id]);
      check($sformatf("v%0d_valid_t2", v), 32'(resp_valid), 32'h0);
      @(negedge clk); // T+3
      check($sformatf("v%0d_valid_t3", v), 32'(resp_valid), 32'h1);
      check($sformatf("v%0d_id", v), 32'(resp_id), 32'(vecs[v].exp_id));
      check($sformatf("v%0d_cos", v), resp_cos, vecs[v].exp_cos);
      check($sformatf("v%0d_sin", v), resp_sin, vecs[v].exp_sin);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_valid", v), 32'(resp_valid), 32'h0);
      check($sformatf("v%0d_done_busy", v), 32'(busy), 32'h0);
    end

    // ---- round-robin with all requesters held high ----
    do_reset();
    begin
      int g_id  [$];
      int g_cyc [$];
      req_valid = 4'b1111;
      drive_lanes();
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          int idx;
          idx = 0;
          for (int b = 0; b < NUM_REQ; b++) if (req_ready[b]) idx = b;
          check($sformatf("rr_onehot_c%0d", c), 32'($countones(req_ready)), 32'h1);
          g_id.push_back(idx);
          g_cyc.push_back(c);
        end
      end
      check("rr_grant_count", 32'(g_id.size()), 32'd5);
      if (g_id.size() == 5) begin
        for (int k = 0; k < 5; k++) begin
          check($sformatf("rr_order_%0d", k), 32'(g_id[k]), 32'(k % 4));
          if (k > 0)
            check($sformatf("rr_spacing_%0d", k), 32'(g_cyc[k] - g_cyc[k-1]), 32'd4);
        end
      end
      req_valid = '0;
    end

    // ---- backpressure and output stability ----
    do_reset();
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    drive_lanes();
    @(negedge clk);
    check("bp_req_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1;
    req_valid = 4'b0001; // another requester waits behind the held result
    repeat (2) @(negedge clk);
    check("bp_theta_wait", trig_theta, 32'h01921FB5);
    @(negedge clk); // T+3
    check("bp_valid", 32'(resp_valid), 32'h1);
    check("bp_id", 32'(resp_id), 32'd2);
    check("bp_cos", resp_cos, 32'hFF6DE04B);
    check("bp_sin", resp_sin, 32'h01921FB5);
    ovr_cos = 32'hDEADBEEF;
    ovr_sin = 32'hCAFEF00D;
    ovr     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid_%0d", c), 32'(resp_valid), 32'h1);
      check($sformatf("bp_hold_cos_%0d", c), resp_cos, 32'hFF6DE04B);
      check($sformatf("bp_hold_sin_%0d", c), resp_sin, 32'h01921FB5);
      check($sformatf("bp_hold_id_%0d", c), 32'(resp_id), 32'd2);
      check($sformatf("bp_hold_ready_%0d", c), 32'(req_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 32'(resp_valid), 32'h1);
    check("bp_hs_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("bp_after_valid", 32'(resp_valid), 32'h0);
    check("bp_after_ready", 32'(req_ready), 32'b0001);
    ovr = 1'b0;

    // ---- reset during WAIT ----
    do_reset();
    req_valid = 4'b0010;
    drive_lanes();
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("rm_busy_wait", 32'(busy), 32'h1);
    check("rm_theta_wait", trig_theta, 32'h00100000);
    #2 rst_n = 1'b0;
    #1;
    check("rm_busy", 32'(busy), 32'h0);
    check("rm_resp_valid", 32'(resp_valid), 32'h0);
    check("rm_trig_theta", trig_theta, 32'h0);
    check("rm_resp_id", 32'(resp_id), 32'h0);
    check("rm_resp_cos", resp_cos, 32'h0);
    check("rm_resp_sin", resp_sin, 32'h0);
    check("rm_req_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rm_no_stale_%0d", c), 32'(resp_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("rm_rr_ptr_zero", 32'(req_ready), 32'b0001);
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trig_share_arbiter.md
Name: trig_share_arbiter

Overview:
- Time-shares one combinational sine/cosine unit (Q8.24 angle in, Q8.24 cos/sin out) among NUM_REQ requesters.
- Round-robin grant; the accepted angle is held stable on the unit input for SETTLE_CYCLES (multi-cycle path), then cos/sin are registered and returned.
- Result carries the requester ID and uses a valid/ready response handshake.
- Sits between requester blocks and the shared trig unit; exactly one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, angle/result width, signed Q8.24
- SETTLE_CYCLES, 2, cycles the trig unit input is held before cos/sin are sampled (>=1)
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_theta  input  NUM_REQ*DATA_W  packed angles; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot grant; transfer happens when req_valid[i] and req_ready[i] are both high
- trig_theta  output  DATA_W  angle driven to the shared trig unit
- trig_cos  input  DATA_W  cosine from the shared trig unit
- trig_sin  input  DATA_W  sine from the shared trig unit
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts result
- resp_id  output  ID_W  index of the requester that owns the result
- resp_cos  output  DATA_W  registered cosine
- resp_sin  output  DATA_W  registered sine
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, theta_q=0, cnt=0, resp_valid=0, resp_id=0, resp_cos=0, resp_sin=0, busy=0. req_ready is 0 during reset.
- trig_theta = theta_q at all times (registered, glitch-free).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is combinational and one-hot at bit g; it is all-zero if no request is pending.
  - On the clock edge with a grant: theta_q<=req_theta[g], id_q<=g, rr_ptr<=(g+1) mod NUM_REQ, cnt<=SETTLE_CYCLES, state<=WAIT.
- WAIT:
  - req_ready=0; cnt decrements once per cycle.
  - On the edge where cnt==1: resp_cos<=trig_cos, resp_sin<=trig_sin, resp_id<=id_q, resp_valid<=1, state<=RESP.
- RESP:
  - resp_valid is held high; resp_cos, resp_sin and resp_id are held stable while resp_ready=0.
  - On the edge with resp_ready=1: resp_valid<=0, state<=IDLE.
- Latency: accept edge at end of cycle T. trig_theta is valid from T+1. resp_valid rises in cycle T+SETTLE_CYCLES+1.
- Throughput, with resp_ready tied high: one op per SETTLE_CYCLES+2 cycles.
- No grant is issued in WAIT or RESP; the next grant is evaluated in the first IDLE cycle after the response handshake.
- A requester may drop req_valid before it is granted; nothing is captured for it.
- req_theta[i] needs to be stable only during the grant cycle.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Arithmetic: cos/sin pass through unmodified; no sign or width conversion is applied. cnt is clog2(SETTLE_CYCLES+1) bits wide.
- Reset mid-operation: any in-flight op is dropped, all outputs return to their reset values immediately, and no response is emitted after reset release.

Test Plan:
1. Single request. req_valid=4'b0001, theta=0x00000000, resp_ready=1, trig model cos=0x01000000 sin=0 -> req_ready=4'b0001 for one cycle; resp_valid in cycle T+3 with resp_id=0, resp_cos=0x01000000, resp_sin=0x00000000.
2. Round-robin. All four req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0; grants spaced 4 cycles apart (SETTLE_CYCLES=2).
3. Backpressure. Req 2 with theta=0x01921FB5 (pi/2); resp_ready=0 for 5 cycles -> resp_valid stays high with resp_id=2 and resp_cos/resp_sin frozen; no new req_ready until 1 cycle after resp_ready=1.
4. Stability. Change trig_cos/trig_sin in the RESP state -> resp_cos/resp_sin unchanged. trig_theta must equal the captured angle for every cycle of WAIT.
5. Reset mid-op. Assert rst_n=0 during the WAIT state -> busy=0, resp_valid=0, all outputs 0 asynchronously; after release, rr_ptr=0 and no stale response appears.
6. Skip idle requesters. rr_ptr=1 with only req 0 valid -> req_ready=4'b0001 and the next rr_ptr is 1.
